// File: rtl/approx_add_error_monitor_pkg.sv
// Shared types and width rules for the approximate-adder error monitors.
package approx_mon_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        REPORT  = 2'd2
    } state_t;

    // Absolute-error accumulator: a full window of maximum-size errors cannot overflow it.
    function automatic int acc_w(input int width, input int win_log2);
        return width + 1 + win_log2;
    endfunction

    function automatic int bias_w(input int width, input int win_log2);
        return acc_w(width, win_log2) + 1;
    endfunction

endpackage

// File: rtl/approx_add_error_monitor_if.sv
// Sample stream and report stream of the error monitor.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both 1; valid holds its payload until then.
interface approx_add_error_monitor_if
    import approx_mon_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int WIN_LOG2 = 8
);
    localparam int ACC_W  = acc_w(WIDTH, WIN_LOG2);
    localparam int BIAS_W = bias_w(WIDTH, WIN_LOG2);

    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_a;
    logic [WIDTH-1:0]    in_b;
    logic [WIDTH:0]      in_sum;
    logic                rpt_valid;
    logic                rpt_ready;
    logic [ACC_W-1:0]    rpt_abs_sum;
    logic [BIAS_W-1:0]   rpt_bias;
    logic [WIDTH:0]      rpt_max;
    logic [WIN_LOG2:0]   rpt_err_cnt;

    modport master (
        output in_valid, in_a, in_b, in_sum, rpt_ready,
        input  in_ready, rpt_valid, rpt_abs_sum, rpt_bias, rpt_max, rpt_err_cnt
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sum, rpt_ready,
        output in_ready, rpt_valid, rpt_abs_sum, rpt_bias, rpt_max, rpt_err_cnt
    );

endinterface

// File: rtl/approx_add_error_monitor_err_calc.sv
// Combinational error of one approximate sum against the exact sum a+b.
module approx_err_calc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    input  logic [WIDTH:0]          sum,
    output logic signed [WIDTH+1:0] diff,
    output logic [WIDTH:0]          absd,
    output logic                    err
);
    logic [WIDTH+1:0] exact;

    assign exact = {2'b00, a} + {2'b00, b};
    assign diff  = signed'({1'b0, sum} - exact);
    // Both sums lie in [0, 2**(WIDTH+1)-1], so the magnitude fits in WIDTH+1 bits.
    assign absd  = diff[WIDTH+1] ? (WIDTH+1)'(-diff) : (WIDTH+1)'(diff);
    assign err   = (diff != '0);

endmodule

// File: rtl/approx_add_error_monitor.sv
// Windowed error statistics (MAE, max, error count, bias) for an approximate adder.
module approx_add_error_monitor
    import approx_mon_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int WIN_LOG2 = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    approx_add_error_monitor_if.slave    bus,
    output state_t                       dbg_state
);
    localparam int ACC_W  = acc_w(WIDTH, WIN_LOG2);
    localparam int BIAS_W = bias_w(WIDTH, WIN_LOG2);
    localparam logic [WIN_LOG2:0] WIN_N    = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [WIN_LOG2:0] WIN_LAST = WIN_N - 1'b1;

    state_t                  state, state_next;
    logic                    in_ready, rpt_valid, accept, done;
    logic [WIN_LOG2:0]       count;
    logic signed [WIDTH+1:0] diff, s1_diff;
    logic [WIDTH:0]          absd, s1_absd;
    logic                    err, s1_err, s1_valid;
    logic [ACC_W-1:0]        abs_sum;
    logic [BIAS_W-1:0]       bias;
    logic [WIDTH:0]          max_err;
    logic [WIN_LOG2:0]       err_cnt;

    approx_err_calc #(.WIDTH(WIDTH)) u_calc (
        .a    (bus.in_a),
        .b    (bus.in_b),
        .sum  (bus.in_sum),
        .diff (diff),
        .absd (absd),
        .err  (err)
    );

    assign accept = bus.in_valid && in_ready;
    assign done   = rpt_valid && bus.rpt_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        rpt_valid  = 1'b0;
        case (state)
            COLLECT: begin
                in_ready = (count < WIN_N);
                if (bus.in_valid && count == WIN_LAST) state_next = DRAIN;
            end
            DRAIN:   state_next = REPORT;
            REPORT: begin
                rpt_valid = 1'b1;
                if (bus.rpt_ready) state_next = COLLECT;
            end
            default: state_next = COLLECT;
        endcase
        if (clear) state_next = COLLECT;
    end

    // Stage 1 registers the per-sample error; stage 2 folds it into the window totals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            s1_valid <= 1'b0;
            s1_diff  <= '0;
            s1_absd  <= '0;
            s1_err   <= 1'b0;
            abs_sum  <= '0;
            bias     <= '0;
            max_err  <= '0;
            err_cnt  <= '0;
        end else if (clear || done) begin
            count    <= '0;
            s1_valid <= 1'b0;
            abs_sum  <= '0;
            bias     <= '0;
            max_err  <= '0;
            err_cnt  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_diff <= diff;
                s1_absd <= absd;
                s1_err  <= err;
                count   <= count + 1'b1;
            end
            if (s1_valid) begin
                abs_sum <= abs_sum + ACC_W'(s1_absd);
                bias    <= bias + {{(BIAS_W-WIDTH-2){s1_diff[WIDTH+1]}}, s1_diff};
                if (s1_absd > max_err) max_err <= s1_absd;
                err_cnt <= err_cnt + (WIN_LOG2+1)'(s1_err);
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.rpt_valid   = rpt_valid;
    assign bus.rpt_abs_sum = abs_sum;
    assign bus.rpt_bias    = bias;
    assign bus.rpt_max     = max_err;
    assign bus.rpt_err_cnt = err_cnt;
    assign dbg_state       = state;

endmodule
